// File: rtl/stage_seq_pkg.sv
// stage_sequencer shared types.
// FSM states and fault codes.
package stage_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    WAIT_MFC,
    HOLD,
    FAULT
  } seq_state_e;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_MEMERR  = 2'b10;
  localparam logic [1:0] FC_BOTH    = 2'b11;

endpackage

// File: rtl/stage_sequencer_step_edge_detect.sv
// Registered rising-edge detector
// for the debug Step button.
module step_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  output logic rise
);

  logic step_q;

  // previous Step level
  always_ff @(posedge clk) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end

  assign rise = step & ~step_q;

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer.
// Optional: STAGE_SEQ_PERF_COUNTERS_EN.
module stage_sequencer #(
  parameter int NUM_STAGES  = 5,
  parameter int STAGE_W     = 4,
  parameter int FETCH_STAGE = 1,
  parameter int MEM_STAGE   = 4,
  parameter int TIMEOUT_W   = 8,
  parameter int MFC_TIMEOUT = 200
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Run,
  input  logic               Step_Mode,
  input  logic               Step,
  input  logic               Mem_Needed,
  input  logic               MEM_MFC,
  input  logic               MEM_ERROR,
  input  logic               Clear_Fault,
  output logic [STAGE_W-1:0] Stage,
  output logic               Stage_Start,
  output logic               Stall,
  output logic               Instr_Done,
`ifdef STAGE_SEQ_PERF_COUNTERS_EN
  output logic [31:0]        Instr_Count,
  output logic [31:0]        Stall_Count,
`endif
  output logic               Fault,
  output logic [1:0]         Fault_Code
);

  import stage_seq_pkg::*;

  localparam logic [STAGE_W-1:0] LAST =
    STAGE_W'(NUM_STAGES);
  localparam logic [STAGE_W-1:0] FIRST =
    STAGE_W'(1);
  localparam logic [STAGE_W-1:0] FETCH =
    STAGE_W'(FETCH_STAGE);
  localparam logic [STAGE_W-1:0] MEM =
    STAGE_W'(MEM_STAGE);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST =
    TIMEOUT_W'(MFC_TIMEOUT - 1);

  seq_state_e           state_q, state_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [STAGE_W-1:0]   nxt;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [1:0]           fc_q, fc_d;
  logic                 start_q, start_d;
  logic                 adv;
  logic                 done;
  logic                 tmo_hit;
  logic                 step_rise;

  step_edge_detect u_step (
    .clk   (Clock),
    .rst_n (Reset_n),
    .step  (Step),
    .rise  (step_rise)
  );

  // Mem_Needed is taken on the edge
  // that opens the stage.
  function automatic logic waits(
    input logic [STAGE_W-1:0] s,
    input logic               mem
  );
    return (s == FETCH) ||
           ((s == MEM) && mem);
  endfunction

  assign nxt = (stage_q == LAST) ?
    FIRST : stage_q + 1'b1;
  assign tmo_hit = (tmo_q == TMO_LAST);

  // next-state and stage decode
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    start_d = 1'b0;
    tmo_d   = '0;
    fc_d    = fc_q;
    adv     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Run) begin
          stage_d = FIRST;
          start_d = 1'b1;
          state_d = waits(FIRST, Mem_Needed) ?
            WAIT_MFC : RUN;
        end
      end
      RUN: begin
        if (Step_Mode) state_d = HOLD;
        else           adv = 1'b1;
      end
      WAIT_MFC: begin
        if (MEM_ERROR) begin
          state_d = FAULT;
          stage_d = '0;
          fc_d = (tmo_hit && !MEM_MFC) ?
            FC_BOTH : FC_MEMERR;
        end else if (MEM_MFC) begin
          if (Step_Mode) state_d = HOLD;
          else           adv = 1'b1;
        end else if (tmo_hit) begin
          state_d = FAULT;
          stage_d = '0;
          fc_d    = FC_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      HOLD: begin
        if (!Step_Mode)     state_d = RUN;
        else if (step_rise) adv = 1'b1;
      end
      FAULT: begin
        if (Clear_Fault) begin
          state_d = IDLE;
          fc_d    = FC_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        stage_d = '0;
      end
    endcase
    if (adv) begin
      done = (stage_q == LAST);
      if (done && !Run) begin
        state_d = IDLE;
        stage_d = '0;
      end else begin
        stage_d = nxt;
        start_d = 1'b1;
        state_d = waits(nxt, Mem_Needed) ?
          WAIT_MFC : RUN;
      end
    end
  end

  // state registers
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      tmo_q   <= '0;
      fc_q    <= FC_NONE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      tmo_q   <= tmo_d;
      fc_q    <= fc_d;
      start_q <= start_d;
    end
  end

  assign Stage       = stage_q;
  assign Stage_Start = start_q;
  assign Stall       = (state_q == WAIT_MFC);
  assign Instr_Done  = done;
  assign Fault       = (state_q == FAULT);
  assign Fault_Code  = fc_q;

`ifdef STAGE_SEQ_PERF_COUNTERS_EN
  logic [31:0] icnt_q, scnt_q;

  // instruction and stall counters
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      icnt_q <= '0;
      scnt_q <= '0;
    end else begin
      icnt_q <= icnt_q + {31'd0, done};
      scnt_q <= scnt_q + {31'd0, Stall};
    end
  end

  assign Instr_Count = icnt_q;
  assign Stall_Count = scnt_q;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer.
// NUM_STAGES=5, MFC_TIMEOUT=10.
module tb_stage_sequencer;

  logic       Clock = 1'b0;
  logic       Reset_n, Run, Step_Mode, Step;
  logic       Mem_Needed, MEM_MFC, MEM_ERROR;
  logic       Clear_Fault;
  logic [3:0] Stage;
  logic       Stage_Start, Stall, Instr_Done;
  logic       Fault;
  logic [1:0] Fault_Code;
`ifdef STAGE_SEQ_PERF_COUNTERS_EN
  logic [31:0] Instr_Count, Stall_Count;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 Clock = ~Clock;

  stage_sequencer #(
    .NUM_STAGES  (5),
    .STAGE_W     (4),
    .FETCH_STAGE (1),
    .MEM_STAGE   (4),
    .TIMEOUT_W   (8),
    .MFC_TIMEOUT (10)
  ) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .Run         (Run),
    .Step_Mode   (Step_Mode),
    .Step        (Step),
    .Mem_Needed  (Mem_Needed),
    .MEM_MFC     (MEM_MFC),
    .MEM_ERROR   (MEM_ERROR),
    .Clear_Fault (Clear_Fault),
    .Stage       (Stage),
    .Stage_Start (Stage_Start),
    .Stall       (Stall),
    .Instr_Done  (Instr_Done),
`ifdef STAGE_SEQ_PERF_COUNTERS_EN
    .Instr_Count (Instr_Count),
    .Stall_Count (Stall_Count),
`endif
    .Fault       (Fault),
    .Fault_Code  (Fault_Code)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 0; Run = 0; Step_Mode = 0;
    Step = 0; Mem_Needed = 0; MEM_MFC = 0;
    MEM_ERROR = 0; Clear_Fault = 0;
    tick(); tick();
    checks++;
    if ({Stage, Stall, Stage_Start, Instr_Done,
         Fault, Fault_Code} !== 10'd0) begin
      $display("FAIL reset_outs got stg=%0d st=%b ss=%b d=%b f=%b fc=%b want all 0",
        Stage, Stall, Stage_Start, Instr_Done,
        Fault, Fault_Code);
      fails++;
    end
    Reset_n = 1;
    tick();
    checks++;
    if (Stage !== 4'd0) begin
      $display("FAIL reset_idle got %0d want 0", Stage);
      fails++;
    end
  endtask

  task automatic test_free_run();
    logic [3:0] exp;
    MEM_MFC = 1; Mem_Needed = 0; Run = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      exp = 4'((i % 5) + 1);
      checks++;
      if (Stage !== exp || Stall !== (exp == 1) ||
          Instr_Done !== (exp == 5) ||
          Stage_Start !== 1'b1) begin
        $display("FAIL free_run[%0d] got stg=%0d st=%b d=%b ss=%b want stg=%0d st=%b d=%b ss=1",
          i, Stage, Stall, Instr_Done, Stage_Start,
          exp, exp == 1, exp == 5);
        fails++;
      end
    end
    Run = 0;
    tick();
    checks++;
    if (Stage !== 4'd0 || Stage_Start !== 1'b0) begin
      $display("FAIL free_stop got stg=%0d ss=%b want 0 0",
        Stage, Stage_Start);
      fails++;
    end
  endtask

  task automatic test_mem_wait();
    MEM_MFC = 1; Mem_Needed = 1; Run = 1;
    tick(); tick(); tick();
    MEM_MFC = 0;
    tick();
    for (int j = 0; j < 7; j++) begin
      checks++;
      if (Stage !== 4'd4 || Stall !== 1'b1 ||
          dut.tmo_q !== 8'(j)) begin
        $display("FAIL mem_wait[%0d] got stg=%0d st=%b cnt=%0d want 4 1 %0d",
          j, Stage, Stall, dut.tmo_q, j);
        fails++;
      end
      if (j < 6) tick();
    end
    MEM_MFC = 1;
    Run = 0;
    tick();
    checks++;
    if (Stage !== 4'd5 || Stall !== 1'b0 ||
        Stage_Start !== 1'b1 || dut.tmo_q !== 8'd0) begin
      $display("FAIL mem_done got stg=%0d st=%b ss=%b cnt=%0d want 5 0 1 0",
        Stage, Stall, Stage_Start, dut.tmo_q);
      fails++;
    end
    tick();
    Mem_Needed = 0;
  endtask

  task automatic test_timeout();
    MEM_MFC = 0; Run = 1;
    tick();
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (Stall !== 1'b1 || Fault !== 1'b0 ||
          Stage !== 4'd1) begin
        $display("FAIL tmo_stall[%0d] got st=%b f=%b stg=%0d want 1 0 1",
          j, Stall, Fault, Stage);
        fails++;
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (Fault !== 1'b1 || Fault_Code !== 2'b01 ||
          Stage !== 4'd0 || Stall !== 1'b0) begin
        $display("FAIL tmo_fault[%0d] got f=%b fc=%b stg=%0d st=%b want 1 01 0 0",
          k, Fault, Fault_Code, Stage, Stall);
        fails++;
      end
      tick();
    end
    Clear_Fault = 1; Run = 0;
    tick();
    Clear_Fault = 0;
    checks++;
    if (Fault !== 1'b0 || Fault_Code !== 2'b00 ||
        Stage !== 4'd0) begin
      $display("FAIL tmo_clear got f=%b fc=%b stg=%0d want 0 00 0",
        Fault, Fault_Code, Stage);
      fails++;
    end
  endtask

  task automatic test_error_priority();
    MEM_MFC = 1; Mem_Needed = 1; Run = 1;
    tick(); tick(); tick();
    MEM_ERROR = 1;
    tick();
    checks++;
    if (Stage !== 4'd4 || Stall !== 1'b1) begin
      $display("FAIL err_in4 got stg=%0d st=%b want 4 1",
        Stage, Stall);
      fails++;
    end
    tick();
    checks++;
    if (Fault !== 1'b1 || Fault_Code !== 2'b10 ||
        Stage !== 4'd0) begin
      $display("FAIL err_prio got f=%b fc=%b stg=%0d want 1 10 0",
        Fault, Fault_Code, Stage);
      fails++;
    end
    MEM_ERROR = 0; Run = 0; Mem_Needed = 0;
    Clear_Fault = 1;
    tick();
    Clear_Fault = 0;
  endtask

  task automatic test_both();
    MEM_MFC = 0; Run = 1;
    tick();
    for (int j = 0; j < 9; j++) tick();
    MEM_ERROR = 1;
    tick();
    checks++;
    if (Fault !== 1'b1 || Fault_Code !== 2'b11) begin
      $display("FAIL err_tmo got f=%b fc=%b want 1 11",
        Fault, Fault_Code);
      fails++;
    end
    MEM_ERROR = 0; Run = 0; Clear_Fault = 1;
    tick();
    Clear_Fault = 0;
  endtask

  task automatic test_step_mode();
    MEM_MFC = 1; Step = 1; Step_Mode = 1;
    tick();
    Run = 1;
    tick(); tick();
    for (int j = 0; j < 20; j++) begin
      tick();
      checks++;
      if (Stage !== 4'd1 || Stall !== 1'b0) begin
        $display("FAIL step_level[%0d] got stg=%0d st=%b want 1 0",
          j, Stage, Stall);
        fails++;
      end
    end
    Step = 0;
    tick(); tick();
    for (int p = 1; p <= 3; p++) begin
      Step = 1;
      tick();
      Step = 0;
      tick(); tick();
      checks++;
      if (Stage !== 4'(p + 1) || Stage_Start !== 1'b0) begin
        $display("FAIL step_pulse[%0d] got stg=%0d ss=%b want %0d 0",
          p, Stage, Stage_Start, p + 1);
        fails++;
      end
    end
    Run = 0; Step_Mode = 0;
    tick(); tick();
    checks++;
    if (Stage !== 4'd5 || Instr_Done !== 1'b1) begin
      $display("FAIL step_resume got stg=%0d d=%b want 5 1",
        Stage, Instr_Done);
      fails++;
    end
    tick();
  endtask

  task automatic test_run_drop();
    MEM_MFC = 1; Run = 1;
    tick(); tick();
    Run = 0;
    for (int s = 3; s <= 5; s++) begin
      tick();
      checks++;
      if (Stage !== 4'(s) ||
          Instr_Done !== (s == 5)) begin
        $display("FAIL run_drop[%0d] got stg=%0d d=%b want %0d %b",
          s, Stage, Instr_Done, s, s == 5);
        fails++;
      end
    end
    tick(); tick();
    checks++;
    if (Stage !== 4'd0 || Stage_Start !== 1'b0) begin
      $display("FAIL run_stop got stg=%0d ss=%b want 0 0",
        Stage, Stage_Start);
      fails++;
    end
  endtask

  task automatic test_reset_mid_stall();
    MEM_MFC = 0; Run = 1;
    tick(); tick(); tick(); tick();
    Reset_n = 0;
    tick();
    checks++;
    if (Stage !== 4'd0 || Stall !== 1'b0 ||
        Fault_Code !== 2'b00 ||
        dut.tmo_q !== 8'd0) begin
      $display("FAIL reset_stall got stg=%0d st=%b fc=%b cnt=%0d want 0 0 00 0",
        Stage, Stall, Fault_Code, dut.tmo_q);
      fails++;
    end
    Reset_n = 1; Run = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_mem_wait();
    test_timeout();
    test_error_priority();
    test_both();
    test_step_mode();
    test_run_drop();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures",
      checks, fails);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Parametrised multi-cycle stage sequencer that drives the processor's Stage number.
- Stage runs 1..NUM_STAGES and gates the control-signal generator.
- Generalises the fixed 5-stage count: configurable stage count and memory-stage positions, MEM_MFC wait handshake with timeout, MEM_ERROR fault capture, single-step debug mode, graceful stop.
- Sits between the board inputs/memory interface and the control-signal generator.

Parameters:
- NUM_STAGES, 5, number of stages per instruction (2..15).
- STAGE_W, 4, width of the Stage output; must hold NUM_STAGES.
- FETCH_STAGE, 1, stage that always waits for MEM_MFC.
- MEM_STAGE, 4, stage that waits for MEM_MFC only when Mem_Needed=1.
- TIMEOUT_W, 8, width of the stall timeout counter.
- MFC_TIMEOUT, 200, stall cycles before a timeout fault (1..2^TIMEOUT_W-1).

Ports:
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  synchronous, active-low reset.
- Run  in  1  level; 1 = execute instructions.
- Step_Mode  in  1  1 = advance one stage per Step rising edge.
- Step  in  1  debug step button; edge-detected internally.
- Mem_Needed  in  1  current instruction accesses memory in MEM_STAGE.
- MEM_MFC  in  1  memory function complete.
- MEM_ERROR  in  1  memory error.
- Clear_Fault  in  1  leave FAULT.
- Stage  out  STAGE_W  current stage; 0 when idle or faulted.
- Stage_Start  out  1  one-cycle pulse in the first cycle of each stage.
- Stall  out  1  waiting for MEM_MFC.
- Instr_Done  out  1  one-cycle pulse when the last stage completes.
- Fault  out  1  in FAULT state.
- Fault_Code  out  2  00 none, 01 timeout, 10 MEM_ERROR, 11 MEM_ERROR with a pending timeout.

Behaviour:
- Reset (Reset_n=0 at an edge, any state, including mid-stall):
  - state IDLE; Stage=0.
  - Stall, Stage_Start, Instr_Done, Fault = 0; Fault_Code=00.
  - Timeout counter and step-edge register = 0.
- States are IDLE, RUN, WAIT_MFC, HOLD, FAULT.
- IDLE:
  - Run=1 -> RUN, Stage=1, Stage_Start=1 in the next cycle.
- RUN, stage s (s is not a waiting stage):
  - Step_Mode=0: advance one cycle later.
  - Step_Mode=1: go to HOLD.
- Waiting stages:
  - s==FETCH_STAGE, or s==MEM_STAGE with Mem_Needed sampled at that stage's first cycle = 1.
  - The stage enters WAIT_MFC; Stall=1 from its first cycle.
- WAIT_MFC:
  - Timeout counter increments each cycle.
  - MEM_MFC=1 -> Stall drops in the next cycle, then advance (or HOLD if Step_Mode).
  - MEM_ERROR=1 -> FAULT, code 10. Error beats a simultaneous MFC.
  - Counter == MFC_TIMEOUT-1 without MFC -> FAULT, code 01.
  - Error on the same edge as the timeout -> code 11.
  - Counter clears on every stage change.
- HOLD:
  - Stage is frozen.
  - A rising edge on Step (Step=1 and previous Step=0) advances one stage.
  - Step_Mode dropping to 0 resumes RUN.
- Advance:
  - s<NUM_STAGES: s+1.
  - s==NUM_STAGES: Instr_Done pulses in the cycle the last stage completes. Then:
    - Run=1: next Stage=1 (wrap).
    - Run=0: IDLE, Stage=0.
- Run falling mid-instruction does not abort; the instruction completes all stages first.
- FAULT:
  - Stage=0, Fault=1, Fault_Code held.
  - Clear_Fault=1 -> IDLE with Fault_Code=00. Run is ignored until cleared.
- Stage_Start is asserted exactly once per stage visit, including re-entry of Stage 1 on wrap.

Optional Feature:
- Macro STAGE_SEQ_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs Instr_Count[31:0] (increments on Instr_Done) and Stall_Count[31:0] (increments each cycle Stall=1).
  - Both are cleared by reset and wrap at 2^32.
- Undefined:
  - Ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package stage_seq_pkg holds:
  - state enum (IDLE, RUN, WAIT_MFC, HOLD, FAULT).
  - Fault_Code constants FC_NONE/FC_TIMEOUT/FC_MEMERR/FC_BOTH.
- One sub-module, step_edge_detect: registered rising-edge detector for Step.
  - Synchronous active-low reset.

Test Plan:
- Free run: NUM_STAGES=5, Run=1, MEM_MFC tied 1, Mem_Needed=0 -> Stage 1,(stall 1 cycle),2,3,4,5,1…; Instr_Done pulses once per instruction; Stall high only in Stage 1.
- Memory wait: Mem_Needed=1, MEM_MFC asserted 7 cycles into Stage 4 -> Stall=1 for 7 cycles, then Stage=5; timeout counter cleared.
- Timeout: MFC_TIMEOUT=10, MEM_MFC=0 in Stage 1 -> after 10 stall cycles Fault=1, Fault_Code=01, Stage=0. Clear_Fault -> IDLE, code 00.
- Error priority: MEM_ERROR and MEM_MFC both high in Stage 4 -> Fault_Code=10; Stage never reaches 5.
- Step mode: Step_Mode=1, Step held high 20 cycles then low, pulsed 3 times -> exactly one advance per rising edge; Stage goes 1->2->3->4.
- Reset/stop: Run dropped in Stage 2 -> completes 3,4,5, Instr_Done, then Stage=0. Separately, Reset_n=0 during WAIT_MFC -> next edge Stage=0, Stall=0, Fault_Code=00.
